// File: rtl/booth_mul_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier.
//   - FSM state encodings (2-bit)
//   - Booth step operation codes, formed as {q[0], q_m1}
package booth_mul_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Booth step adder/subtractor (combinational).
// Ports:
//   acc  in  W  current accumulator
//   m    in  W  sign-extended multiplicand
//   op   in  2  Booth op code {q[0], q_m1}
//   sum  out W  acc, acc+m or acc-m
module booth_addsub
    import booth_mul_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] m,
    input  logic [1:0]   op,
    output logic [W-1:0] sum
);

    // Codes 00 and 11 both mean "no change" in radix-2 Booth recoding.
    always_comb begin
        sum = acc;
        case (op)
            OP_NOP:  sum = acc;
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock,
// N steps per product, one-cycle done pulse.
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request, accepted only in IDLE or DONE
//   a        in   N   signed multiplicand
//   b        in   N   signed multiplier
//   busy     out  1   high while iterating
//   done     out  1   one-cycle completion pulse
//   product  out  2N  signed a*b, held until the next completion
module booth_seq_multiplier
    import booth_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state, state_next;
    // Accumulator is one bit wider than the operands so that subtracting
    // m = -2^(N-1) cannot overflow.
    logic [N:0]    acc, m, sum, acc_next;
    logic [N-1:0]  q, q_next;
    logic          q_m1;
    logic [CW-1:0] cnt;
    logic          load, last_step;

    assign load      = start && (state == S_IDLE || state == S_DONE);
    assign last_step = (state == S_CALC) && (cnt == CNT_LAST);

    booth_addsub #(.W(N + 1)) u_addsub (
        .acc (acc),
        .m   (m),
        .op  ({q[0], q_m1}),
        .sum (sum)
    );

    // Arithmetic right shift of {sum, q, q_m1}.
    assign acc_next = {sum[N], sum[N:1]};
    assign q_next   = {sum[0], q[N-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_CALC : S_IDLE;
            S_CALC:  state_next = last_step ? S_DONE : S_CALC;
            S_DONE:  state_next = start ? S_CALC : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register, so they are
    // glitch-free and mutually exclusive.
    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            m    <= {a[N-1], a};
            acc  <= '0;
            q    <= b;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else if (state == S_CALC) begin
            acc  <= acc_next;
            q    <= q_next;
            q_m1 <= q[0];
            cnt  <= cnt + 1'b1;
            // Top bit of acc_next is only a sign copy once the product fits 2N bits.
            if (last_step) product <= {acc_next[N-1:0], q_next};
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    booth_seq_multiplier #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a start at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after acceptance (k=1). Waits for done,
    // checks latency, busy length, held product and final product.
    // poke_k > 0 pulses start with junk operands at that cycle.
    task automatic finish_op(input logic [15:0] exp, input logic [15:0] prev, input int poke_k);
        int done_k;
        int busy_cnt;
        done_k = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (poke_k > 0 && k == poke_k + 1) start = 1'b0;
            if (done) begin
                done_k = k;
                break;
            end
            if (busy) busy_cnt++;
            if (k == 4) check("product_hold_calc", {16'h0, product}, {16'h0, prev});
            if (poke_k > 0 && k == poke_k) begin
                start = 1'b1; a = 8'd100; b = 8'd100;
            end
        end
        check("done_latency", done_k, 9);
        check("busy_cycles", busy_cnt, 8);
        check("busy_in_done", {31'h0, busy}, 32'h0);
        check("product", {16'h0, product}, {16'h0, exp});
    endtask

    initial begin
        vec_t vecs[7];
        logic [15:0] prev;
        int spurious;

        vecs[0] = '{8'h03, 8'hFC, 16'hFFF4};   //    3 *   -4
        vecs[1] = '{8'h80, 8'h80, 16'h4000};   // -128 * -128
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};   // -128 *  127
        vecs[3] = '{8'h00, 8'hFF, 16'h0000};   //    0 *   -1
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01};   //  127 *  127
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};   //   -1 *   -1
        vecs[6] = '{8'h01, 8'h80, 16'hFF80};   //    1 * -128

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_product", {16'h0, product}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        prev = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b);
            finish_op(vecs[i].p, prev, 0);
            repeat (2) @(negedge clk);
            check("idle_busy", {31'h0, busy}, 32'h0);
            check("idle_done", {31'h0, done}, 32'h0);
            check("product_hold_idle", {16'h0, product}, {16'h0, vecs[i].p});
            prev = vecs[i].p;
        end

        // start during CALC with changed operands is ignored
        launch(8'h03, 8'hFC);
        finish_op(16'hFFF4, prev, 3);
        @(negedge clk);
        check("ignored_start_idle", {31'h0, busy}, 32'h0);
        prev = 16'hFFF4;

        // back-to-back: start held in the DONE cycle
        launch(8'h80, 8'h7F);
        finish_op(16'hC080, prev, 0);
        a = 8'h05; b = 8'h06; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", {31'h0, busy}, 32'h1);
        finish_op(16'h001E, 16'hC080, 0);
        prev = 16'h001E;

        // reset mid-CALC
        launch(8'h7F, 8'h7F);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_product", {16'h0, product}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        check("no_spurious_done", spurious, 0);
        launch(8'hF9, 8'h09);
        finish_op(16'hFFC1, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
